// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/format enums, widths and the decoded-instruction record of the 16-bit core
package cpu_pkg;
  localparam int PC_W = 9;
  localparam int REG_W = 4;
  localparam int INSTR_W = 16;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR = 4'h4, OP_ADDI = 4'h5, OP_LUI = 4'h6, OP_MOV = 4'h7,
    OP_ORI = 4'h8, OP_LD = 4'h9, OP_ST = 4'hA, OP_RSV = 4'hB,
    OP_BEQ = 4'hC, OP_BNE = 4'hD, OP_J = 4'hE, OP_HALT = 4'hF
  } opcode_t;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_LD, FMT_SB, FMT_J, FMT_CTRL, FMT_RSV} fmt_t;
  typedef struct packed {
    logic [3:0] op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [7:0] imm;
    logic [REG_W-1:0] rb;
    logic [3:0] disp4;
    logic [PC_W-1:0] disp9;
  } decoded_instr_t;
  function automatic fmt_t op_fmt(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: return FMT_R;
      OP_ADDI, OP_LUI, OP_ORI: return FMT_I;
      OP_LD: return FMT_LD;
      OP_ST, OP_BEQ, OP_BNE: return FMT_SB;
      OP_J: return FMT_J;
      OP_RSV: return FMT_RSV;
      default: return FMT_CTRL;
    endcase
  endfunction
endpackage

// File: rtl/fetch_decode_if.sv
// fetch_decode_if: redirect/stall controls, instruction-memory bus and decoded-field outputs of the front end
//   master (fetch_decode): in stall, is_jump, next_pc, imem_data; out imem_en, imem_addr, valid, op, rd, rs, rb, imm, disp4, disp9, pc, halted
//   slave  (Ex stage + memory): the mirror image
interface fetch_decode_if #(parameter int PC_W = 9);
  logic stall;
  logic is_jump;
  logic [PC_W-1:0] next_pc;
  logic imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [15:0] imem_data;
  logic valid;
  logic halted;
  logic [3:0] op, rd, rs, rb, disp4;
  logic [7:0] imm;
  logic [PC_W-1:0] disp9, pc;
  modport master (
    input stall, is_jump, next_pc, imem_data,
    output imem_en, imem_addr, valid, op, rd, rs, rb, imm, disp4, disp9, pc, halted
  );
  modport slave (
    output stall, is_jump, next_pc, imem_data,
    input imem_en, imem_addr, valid, op, rd, rs, rb, imm, disp4, disp9, pc, halted
  );
endinterface

// File: rtl/instr_decoder.sv
// instr_decoder: combinational slicing of one instruction word into its format's operand fields
//   word_i  in   instruction word (bit 0 of the ISA numbering is the MSB)
//   dec_o   out  decoded fields, unused fields forced to 0
//   valid_o out  0 for the reserved opcode, which is turned into a bubble
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] word_i,
  output decoded_instr_t     dec_o,
  output logic               valid_o
);
  fmt_t fmt;
  always_comb begin
    fmt = op_fmt(word_i[15:12]);
    dec_o.op = (fmt == FMT_RSV) ? 4'h0 : word_i[15:12];
    dec_o.rd = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_LD) ? word_i[11:8] : '0;
    dec_o.rs = (fmt == FMT_R) ? word_i[7:4] : (fmt == FMT_SB) ? word_i[11:8] : '0;
    dec_o.rb = (fmt == FMT_LD || fmt == FMT_SB) ? word_i[7:4] : '0;
    dec_o.imm = (fmt == FMT_I) ? word_i[7:0] : '0;
    dec_o.disp4 = (fmt == FMT_LD || fmt == FMT_SB) ? word_i[3:0] : '0;
    dec_o.disp9 = (fmt == FMT_J) ? word_i[8:0] : '0;
    valid_o = fmt != FMT_RSV;
  end
endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: program counter, instruction fetch and registered decode stage feeding Ex
//   ck, rst  clock and synchronous active-high reset
//   bus      fetch_decode_if.master: stall/is_jump/next_pc from Ex, imem_en/imem_addr/imem_data to the
//            synchronous instruction memory, registered decoded fields plus valid/pc/halted to Ex
module fetch_decode #(
  parameter int PC_W = 9,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic ck,
  input logic rst,
  fetch_decode_if.master bus
);
  import cpu_pkg::*;
  typedef enum logic {S_RUN, S_HALT} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, fa_q, fa_d, opc_q, opc_d;
  logic fl_q, fl_d, valid_q, valid_d, halted_q, halted_d, dec_valid, take;
  logic [INSTR_W-1:0] word;
  decoded_instr_t dec, out_q, out_d;
  assign word = bus.imem_data;
  instr_decoder u_dec (.word_i(word), .dec_o(dec), .valid_o(dec_valid));
  // fl_q tags the word on imem_data as a live fetch from address fa_q; cleared words are squashed
  assign take = fl_q && dec_valid;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    fa_d = fa_q;
    fl_d = fl_q;
    out_d = out_q;
    valid_d = valid_q;
    opc_d = opc_q;
    halted_d = halted_q;
    if (state_q == S_HALT) begin
      fl_d = 1'b0;
      out_d = '0;
      valid_d = 1'b0;
      opc_d = '0;
      halted_d = 1'b1;
    end else if (bus.is_jump) begin
      pc_d = bus.next_pc;
      fl_d = 1'b0;
      out_d = '0;
      valid_d = 1'b0;
      opc_d = '0;
    end else if (!bus.stall) begin
      pc_d = pc_q + 1'b1;
      fa_d = pc_q;
      fl_d = 1'b1;
      out_d = take ? dec : '0;
      valid_d = take;
      opc_d = take ? fa_q : '0;
      // the word fetched alongside the HALT decode never gets used
      if (take && dec.op == OP_HALT) begin
        state_d = S_HALT;
        fl_d = 1'b0;
      end
    end
  end
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q <= RESET_PC;
      fa_q <= '0;
      fl_q <= 1'b0;
      out_q <= '0;
      valid_q <= 1'b0;
      opc_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      fa_q <= fa_d;
      fl_q <= fl_d;
      out_q <= out_d;
      valid_q <= valid_d;
      opc_q <= opc_d;
      halted_q <= halted_d;
    end
  end
  assign bus.imem_en = state_q == S_RUN && !bus.stall && !rst;
  assign bus.imem_addr = pc_q;
  assign bus.valid = valid_q;
  assign bus.op = out_q.op;
  assign bus.rd = out_q.rd;
  assign bus.rs = out_q.rs;
  assign bus.rb = out_q.rb;
  assign bus.imm = out_q.imm;
  assign bus.disp4 = out_q.disp4;
  assign bus.disp9 = out_q.disp9;
  assign bus.pc = opc_q;
  assign bus.halted = halted_q;
endmodule
